// File: rtl/bus_request_arbiter.sv
// Two-master round-robin arbiter feeding a single held vld/addr/data beat
// stream; each granted beat is held for HOLD_CYCLES cycles.
module bus_request_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 16,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_vld,
  output logic              m0_rdy,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data,
  input  logic              m1_vld,
  output logic              m1_rdy,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data,
  output logic              vld,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data,
  output logic              grant_id,
  output logic              busy
);

  localparam int CW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(HOLD_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t            r_state;
  state_t            w_state_nx;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nx;
  logic              r_prio;
  logic              w_prio_nx;
  logic              r_vld;
  logic              w_vld_nx;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr_nx;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data_nx;
  logic              r_gid;
  logic              w_gid_nx;

  logic w_window;
  logic w_any;
  logic w_sel1;
  logic w_xfer;

  // The last hold cycle doubles as an accept window for back-to-back beats.
  always_comb begin
    w_window = (r_state == S_IDLE) || (r_cnt == '0);
    w_any    = m0_vld | m1_vld;
    w_sel1   = m1_vld & (~m0_vld | r_prio);
    w_xfer   = ~rst & w_window & w_any;
    m0_rdy   = w_xfer & ~w_sel1;
    m1_rdy   = w_xfer & w_sel1;
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_prio_nx  = r_prio;
    w_vld_nx   = r_vld;
    w_addr_nx  = r_addr;
    w_data_nx  = r_data;
    w_gid_nx   = r_gid;
    unique case (r_state)
      S_IDLE: begin
        if (w_xfer) begin
          w_state_nx = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt != '0) begin
          w_cnt_nx = r_cnt - CW'(1);
        end else if (!w_xfer) begin
          w_state_nx = S_IDLE;
          w_vld_nx   = 1'b0;
          w_addr_nx  = '0;
          w_data_nx  = '0;
          w_gid_nx   = 1'b0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
    if (w_xfer) begin
      w_state_nx = S_HOLD;
      w_cnt_nx   = CNT_LOAD;
      w_vld_nx   = 1'b1;
      w_gid_nx   = w_sel1;
      w_prio_nx  = ~w_sel1;
      w_addr_nx  = w_sel1 ? m1_addr : m0_addr;
      w_data_nx  = w_sel1 ? m1_data : m0_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prio  <= 1'b0;
      r_vld   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_gid   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_prio  <= w_prio_nx;
      r_vld   <= w_vld_nx;
      r_addr  <= w_addr_nx;
      r_data  <= w_data_nx;
      r_gid   <= w_gid_nx;
    end
  end

  assign vld      = r_vld;
  assign addr     = r_addr;
  assign data     = r_data;
  assign grant_id = r_gid;
  assign busy     = (r_state == S_HOLD);

endmodule

// File: tb/tb_bus_request_arbiter.sv
// Bench for bus_request_arbiter: vector table, hand sequences and random
// traffic against a beat-level reference model (HOLD=2 and HOLD=1 builds).
module tb_bus_request_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        in_rst [2];
  logic        in_v   [2][2];
  logic [7:0]  in_a   [2][2];
  logic [15:0] in_d   [2][2];

  logic        r0_a, r1_a, vld_a, gid_a, busy_a;
  logic [7:0]  addr_a;
  logic [15:0] data_a;
  logic        r0_b, r1_b, vld_b, gid_b, busy_b;
  logic [7:0]  addr_b;
  logic [15:0] data_b;
  logic [28:0] out_a, out_b;

  assign out_a = {r0_a, r1_a, vld_a, addr_a, data_a, gid_a, busy_a};
  assign out_b = {r0_b, r1_b, vld_b, addr_b, data_b, gid_b, busy_b};

  bus_request_arbiter dut_a (
    .clk(clk), .rst(in_rst[0]),
    .m0_vld(in_v[0][0]), .m0_rdy(r0_a),
    .m0_addr(in_a[0][0]), .m0_data(in_d[0][0]),
    .m1_vld(in_v[0][1]), .m1_rdy(r1_a),
    .m1_addr(in_a[0][1]), .m1_data(in_d[0][1]),
    .vld(vld_a), .addr(addr_a), .data(data_a),
    .grant_id(gid_a), .busy(busy_a)
  );

  bus_request_arbiter #(.HOLD_CYCLES(1)) dut_b (
    .clk(clk), .rst(in_rst[1]),
    .m0_vld(in_v[1][0]), .m0_rdy(r0_b),
    .m0_addr(in_a[1][0]), .m0_data(in_d[1][0]),
    .m1_vld(in_v[1][1]), .m1_rdy(r1_b),
    .m1_addr(in_a[1][1]), .m1_data(in_d[1][1]),
    .vld(vld_b), .addr(addr_b), .data(data_b),
    .grant_id(gid_b), .busy(busy_b)
  );

  // Beat-level reference: current beat, cycles it has left, next favourite.
  bit          md_valid [2];
  bit          md_src   [2];
  logic [7:0]  md_addr  [2];
  logic [15:0] md_data  [2];
  int          md_left  [2];
  bit          md_prio  [2];
  int          hold     [2] = '{2, 1};
  bit          acc      [2][2];
  int          p        [2];

  int nvec = 0;
  int nmis = 0;

  typedef struct {
    bit          rst;
    bit          v0;
    logic [7:0]  a0;
    logic [15:0] d0;
    bit          v1;
    logic [7:0]  a1;
    logic [15:0] d1;
    logic [28:0] exp;
  } row_t;

  row_t tbl[$];

  function automatic logic [28:0] pk(bit r0, bit r1, bit v,
      logic [7:0] a, logic [15:0] dd, bit g);
    return {r0, r1, v, a, dd, g, v};
  endfunction

  function automatic row_t mk(bit rs, bit v0, logic [7:0] a0,
      logic [15:0] d0, bit v1, logic [7:0] a1, logic [15:0] d1,
      logic [28:0] e);
    row_t r;
    r.rst = rs; r.v0 = v0; r.a0 = a0; r.d0 = d0;
    r.v1 = v1; r.a1 = a1; r.d1 = d1; r.exp = e;
    return r;
  endfunction

  function automatic bit win1(int d);
    return in_v[d][1] && (!in_v[d][0] || md_prio[d]);
  endfunction

  function automatic bit window(int d);
    return !md_valid[d] || md_left[d] == 1;
  endfunction

  function automatic bit rdy(int d, int m);
    return !in_rst[d] && window(d) && in_v[d][m] &&
           (win1(d) == (m == 1));
  endfunction

  function automatic logic [28:0] model_exp(int d);
    return pk(rdy(d, 0), rdy(d, 1), md_valid[d],
              md_valid[d] ? md_addr[d] : 8'h00,
              md_valid[d] ? md_data[d] : 16'h0000,
              md_valid[d] ? md_src[d] : 1'b0);
  endfunction

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      acc[d][0] = rdy(d, 0);
      acc[d][1] = rdy(d, 1);
      if (in_rst[d]) begin
        md_valid[d] = 0; md_left[d] = 0; md_prio[d] = 0;
      end else if (acc[d][0] || acc[d][1]) begin
        md_src[d]   = acc[d][1];
        md_addr[d]  = in_a[d][acc[d][1]];
        md_data[d]  = in_d[d][acc[d][1]];
        md_valid[d] = 1;
        md_left[d]  = hold[d];
        md_prio[d]  = !acc[d][1];
      end else if (md_valid[d]) begin
        md_left[d]--;
        if (md_left[d] == 0) md_valid[d] = 0;
      end
    end
  endtask

  task automatic check(string name, logic [28:0] act,
      logic [28:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s got=%h want=%h (r0 r1 vld addr data gid busy)",
               name, act, exp);
    end
  endtask

  task automatic check1(string name, logic act, logic exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s got=%b want=%b", name, act, exp);
    end
  endtask

  task automatic cycle(bit t0, logic [28:0] e0, bit t1,
      logic [28:0] e1, string tag);
    @(negedge clk);
    check({tag, "_a"}, out_a, t0 ? e0 : model_exp(0));
    check({tag, "_b"}, out_b, t1 ? e1 : model_exp(1));
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic stim();
    for (int d = 0; d < 2; d++)
      for (int m = 0; m < 2; m++)
        if (acc[d][m] || !in_v[d][m]) begin
          in_v[d][m] = ($urandom_range(99) < p[d]);
          in_a[d][m] = 8'($urandom);
          in_d[d][m] = 16'($urandom);
        end
  endtask

  task automatic set_b(bit v1, logic [7:0] a);
    in_v[1][0] = 0;
    in_v[1][1] = v1;
    in_a[1][1] = a;
    in_d[1][1] = {8'h00, a};
  endtask

  int beats;

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_rst[d] = 1;
      p[d] = 0;
      for (int m = 0; m < 2; m++) begin
        in_v[d][m] = 0; in_a[d][m] = 0; in_d[d][m] = 0;
        acc[d][m] = 0;
      end
    end
    @(posedge clk);
    model_edge();
    #1;

    tbl.push_back(mk(1,1,8'h10,16'h1111,1,8'h80,16'h2222,pk(0,0,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(1,1,8'h10,16'h1111,1,8'h80,16'h2222,pk(0,0,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(1,1,8'h10,16'h1111,1,8'h80,16'h2222,pk(0,0,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(0,1,8'h12,16'hBEEF,0,8'h00,16'h0000,pk(1,0,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,1,8'h12,16'hBEEF,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,1,8'h12,16'hBEEF,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(1,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(0,1,8'h10,16'h1111,1,8'h80,16'h2222,pk(1,0,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,1,8'h80,16'h2222,pk(0,0,1,8'h10,16'h1111,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,1,8'h80,16'h2222,pk(0,1,1,8'h10,16'h1111,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,1,8'h80,16'h2222,1)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,1,8'h80,16'h2222,1)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,1,8'hC0,16'h1234,pk(0,1,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(1,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,1,8'hC0,16'h1234,1)));
    tbl.push_back(mk(0,1,8'h01,16'hAAAA,1,8'h02,16'hBBBB,pk(1,0,0,8'h00,16'h0000,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,1,8'h02,16'hBBBB,pk(0,0,1,8'h01,16'hAAAA,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,1,8'h02,16'hBBBB,pk(0,1,1,8'h01,16'hAAAA,0)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,1,8'h02,16'hBBBB,1)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,1,8'h02,16'hBBBB,1)));
    tbl.push_back(mk(0,0,8'h00,16'h0000,0,8'h00,16'h0000,pk(0,0,0,8'h00,16'h0000,0)));

    foreach (tbl[i]) begin
      in_rst[0]  = tbl[i].rst;
      in_v[0][0] = tbl[i].v0;
      in_a[0][0] = tbl[i].a0;
      in_d[0][0] = tbl[i].d0;
      in_v[0][1] = tbl[i].v1;
      in_a[0][1] = tbl[i].a1;
      in_d[0][1] = tbl[i].d1;
      cycle(1, tbl[i].exp, 0, '0, $sformatf("tbl%0d", i));
    end

    // One-cycle beats: m1 streams 40,41,42 with rdy high each cycle.
    in_rst[1] = 0;
    set_b(1, 8'h40);
    cycle(0, '0, 1, pk(0,1,0,8'h00,16'h0000,0), "h1_0");
    set_b(1, 8'h41);
    cycle(0, '0, 1, pk(0,1,1,8'h40,16'h0040,1), "h1_1");
    set_b(1, 8'h42);
    cycle(0, '0, 1, pk(0,1,1,8'h41,16'h0041,1), "h1_2");
    set_b(0, 8'h00);
    cycle(0, '0, 1, pk(0,0,1,8'h42,16'h0042,1), "h1_3");
    cycle(0, '0, 1, pk(0,0,0,8'h00,16'h0000,0), "h1_4");

    // Sustained load from reset: alternate grants, no bubbles.
    in_rst[0] = 1;
    cycle(0, '0, 0, '0, "sus_rst");
    in_rst[0] = 0;
    for (int m = 0; m < 2; m++) begin
      in_v[0][m] = 1;
      in_a[0][m] = 8'($urandom);
      in_d[0][m] = 16'($urandom);
    end
    p[0] = 100;
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      cycle(0, '0, 0, '0, "sus");
      if (md_valid[0] && md_left[0] == 2) begin
        check1($sformatf("sus_gid%0d", beats), gid_a, beats[0]);
        beats++;
      end
      check1($sformatf("sus_vld%0d", c), vld_a, 1'b1);
      stim();
    end
    nvec++;
    if (beats != 10) begin
      nmis++;
      $display("FAIL sus_beats got=%0d want=10", beats);
    end

    // Random traffic on both builds, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if (c % 100 == 0) begin
        p[0] = $urandom_range(100);
        p[1] = $urandom_range(100);
      end
      in_rst[0] = ($urandom_range(149) == 0);
      in_rst[1] = ($urandom_range(149) == 0);
      cycle(0, '0, 0, '0, "rnd");
      stim();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
